// File: rtl/serial_operand_feeder_pkg.sv
// Shared definitions for the serial adder datapath:
// feeder FSM encoding and default operand width.
package serial_operand_feeder_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/serial_operand_feeder_piso.sv
// Parallel-in serial-out shift register, LSB first,
// zero-filled from the top on every shift.
module piso_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             sout
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge clk) begin
      if (rst || clr)
         q <= '0;
      else if (load)
         q <= din;
      else if (shift)
         q <= {1'b0, q[WIDTH-1:1]};
   end

   assign sout = q[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Loads operand pairs and streams them LSB-first to the
// serial adder with frame markers and a done pulse.
module serial_operand_feeder
   import serial_operand_feeder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             bit_A,
   output logic             bit_B,
   output logic             bit_valid,
   output logic             first_bit,
   output logic             last_bit,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            accept, at_last;
   logic            ld, sh, clr;

   assign at_last    = (cnt == LAST);
   // Ready on the final bit lets frames run back to back.
   assign load_ready = (state == ST_IDLE) |
                       ((state == ST_SHIFT) & at_last);
   assign accept     = load_valid & load_ready;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ld      = 1'b0;
      sh      = 1'b0;
      clr     = 1'b0;
      if (accept) begin
         ld      = 1'b1;
         cnt_n   = '0;
         state_n = ST_SHIFT;
      end else if (state == ST_SHIFT) begin
         if (at_last) begin
            clr     = 1'b1;
            cnt_n   = '0;
            state_n = ST_IDLE;
         end else begin
            sh    = 1'b1;
            cnt_n = cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_valid <= 1'b0;
         first_bit <= 1'b0;
         last_bit  <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_valid <= (state_n == ST_SHIFT);
         first_bit <= ld;
         last_bit  <= (state_n == ST_SHIFT) && (cnt_n == LAST);
         done      <= last_bit;
      end
   end

   piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .load  (ld),
      .shift (sh),
      .din   (a_in),
      .sout  (bit_A)
   );

   piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .load  (ld),
      .shift (sh),
      .din   (b_in),
      .sout  (bit_B)
   );

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: directed table, corner
// sequences and random traffic against a frame-level model.
module tb_serial_operand_feeder;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, load_valid, load_ready;
   logic [W-1:0] a_in, b_in;
   logic         bit_A, bit_B, bit_valid;
   logic         first_bit, last_bit, done;

   logic         rst2, lv2, rdy2;
   logic [1:0]   a2, b2;
   logic         ba2, bb2, bv2, fb2, lb2, dn2;

   serial_operand_feeder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready),
      .a_in(a_in), .b_in(b_in),
      .bit_A(bit_A), .bit_B(bit_B), .bit_valid(bit_valid),
      .first_bit(first_bit), .last_bit(last_bit), .done(done)
   );

   serial_operand_feeder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst2),
      .load_valid(lv2), .load_ready(rdy2),
      .a_in(a2), .b_in(b2),
      .bit_A(ba2), .bit_B(bb2), .bit_valid(bv2),
      .first_bit(fb2), .last_bit(lb2), .done(dn2)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Frame-level model: index of the bit on the wire, or -1.
   int           pos = -1;
   logic [W-1:0] fa = '0, fb = '0;
   logic         done_m = 1'b0;

   typedef struct {
      logic         r;
      logic         lv;
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           chk;
      logic [6:0]   exp;
   } vec_t;

   vec_t vt[13];

   function automatic logic [6:0] model_out();
      logic rdy, bv, ba, bb;
      rdy = (pos < 0) || (pos == W - 1);
      bv  = (pos >= 0);
      ba  = bv ? fa[pos] : 1'b0;
      bb  = bv ? fb[pos] : 1'b0;
      return {rdy, bv, ba, bb, pos == 0, pos == W - 1, done_m};
   endfunction

   function automatic logic [6:0] dut_out();
      return {load_ready, bit_valid, bit_A, bit_B,
              first_bit, last_bit, done};
   endfunction

   function automatic logic [6:0] dut2_out();
      return {rdy2, bv2, ba2, bb2, fb2, lb2, dn2};
   endfunction

   task automatic check(input string nm, input logic [6:0] act,
                        input logic [6:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %b expected %b", nm, act, exp);
   endtask

   task automatic model_edge(input logic r, input logic lv,
                             input logic [W-1:0] a,
                             input logic [W-1:0] b);
      logic rdy;
      rdy = (pos < 0) || (pos == W - 1);
      if (r) begin
         pos = -1; fa = '0; fb = '0; done_m = 1'b0;
      end else begin
         done_m = (pos == W - 1);
         if (lv && rdy) begin
            fa = a; fb = b; pos = 0;
         end else if (pos == W - 1) begin
            pos = -1;
         end else if (pos >= 0) begin
            pos++;
         end
      end
   endtask

   // Called at a falling edge: check, drive, clock, update model.
   task automatic step(input logic r, input logic lv,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit do_chk, input logic [6:0] exp,
                       input string nm);
      if (do_chk) check(nm, dut_out(), exp);
      rst = r; load_valid = lv; a_in = a; b_in = b;
      @(posedge clk);
      model_edge(r, lv, a, b);
      @(negedge clk);
   endtask

   task automatic mstep(input logic r, input logic lv,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input string nm);
      step(r, lv, a, b, 1'b1, model_out(), nm);
   endtask

   int bv_cnt;

   initial begin
      rst = 1'b1; load_valid = 1'b0; a_in = '0; b_in = '0;
      rst2 = 1'b1; lv2 = 1'b0; a2 = '0; b2 = '0;

      // {ready,valid,A,B,first,last,done} seen before each edge
      vt[0]  = '{1'b1, 1'b1, 8'hA5, 8'h3C, 1'b0, 7'b0000000};
      vt[1]  = '{1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1, 7'b1000000};
      vt[2]  = '{1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1, 7'b1000000};
      vt[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 7'b0110100};
      vt[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 7'b0100000};
      vt[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 7'b0111000};
      vt[6]  = '{1'b0, 1'b1, 8'h12, 8'h34, 1'b1, 7'b0101000};
      vt[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 7'b0101000};
      vt[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 7'b0111000};
      vt[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 7'b0100000};
      vt[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 7'b1110010};
      vt[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 7'b1000001};
      vt[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 7'b1000000};

      @(negedge clk);
      for (int i = 0; i < 13; i++)
         step(vt[i].r, vt[i].lv, vt[i].a, vt[i].b, vt[i].chk,
              vt[i].exp, $sformatf("table[%0d]", i));

      // Back-to-back frames with load_valid held high
      bv_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (bit_valid === 1'b1) bv_cnt++;
         if (i == 9)
            check("b2b done+first", {6'b0, done & first_bit}, 7'd1);
         mstep(1'b0, i < 9, (i == 0) ? 8'hFF : 8'h00,
               (i == 0) ? 8'h01 : 8'hFF,
               $sformatf("b2b[%0d]", i));
      end
      check("b2b valid cycles", 7'(bv_cnt), 7'd16);

      // Reset mid-frame at cnt=4, then reload right after
      for (int i = 0; i < 18; i++)
         mstep(i == 5, (i == 0) || (i == 6), 8'hA5, 8'h3C,
               $sformatf("midrst[%0d]", i));

      // Random traffic
      for (int i = 0; i < 400; i++)
         mstep($urandom_range(0, 99) < 3,
               $urandom_range(0, 1) == 1,
               W'($urandom), W'($urandom),
               $sformatf("rand[%0d]", i));

      // WIDTH=2 instance
      rst2 = 1'b0;
      @(negedge clk);
      check("w2 idle", dut2_out(), 7'b1000000);
      lv2 = 1'b1; a2 = 2'b10; b2 = 2'b11;
      @(negedge clk);
      lv2 = 1'b0; a2 = '0; b2 = '0;
      check("w2 bit0", dut2_out(), 7'b0101100);
      @(negedge clk);
      check("w2 bit1", dut2_out(), 7'b1111010);
      @(negedge clk);
      check("w2 done", dut2_out(), 7'b1000001);
      @(negedge clk);
      check("w2 quiet", dut2_out(), 7'b1000000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
